// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word request at a time
// over req/gnt/rvalid, and buffers returned words in a 2-entry FIFO.
// The head of the FIFO is presented to decode. Control/execute redirects
// flush the buffer and kill any response still in flight.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        n_rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [6:0]  if_opcode,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] jalr_target,
  output logic        fetch_fault
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_FULL  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [1:0] FULL_CNT = 2'(FIFO_DEPTH);

  state_t      state_r, state_nxt_s;
  logic [31:0] pc_r, pc_nxt_s;
  logic [31:0] req_pc_r;
  logic        kill_r, kill_nxt_s;
  logic        fault_r, fault_nxt_s;
  logic        req_r;

  logic [1:0]  cnt_r, cnt_nxt_s;
  logic        valid_r;
  logic [31:0] e0_instr_r, e0_pc_r, e1_instr_r, e1_pc_r;
  logic [31:0] e0_instr_nxt_s, e0_pc_nxt_s, e1_instr_nxt_s, e1_pc_nxt_s;

  logic        redirect_s, flush_s, misalign_s;
  logic [31:0] target_s;
  logic        grant_s, resp_s, push_s, pop_s, credit_s;

  // jalr targets have bit0 forced low; anything still not word aligned faults
  assign redirect_s = ((pc_src == 2'd1) && branch_taken) || (pc_src == 2'd2);
  assign target_s   = (pc_src == 2'd2) ? (jalr_target & ~32'd1) : branch_target;
  assign misalign_s = (target_s[1:0] != 2'b00);
  assign flush_s    = redirect_s && (state_r != S_FAULT);

  assign grant_s  = (state_r == S_REQ) && imem_gnt;
  assign resp_s   = (state_r == S_WAIT) && imem_rvalid;
  assign push_s   = resp_s && !kill_r && !flush_s;
  assign pop_s    = valid_r && id_ready;
  // after a response nothing is outstanding, so only the buffer occupancy matters
  assign credit_s = (cnt_nxt_s < FULL_CNT);

  assign imem_req    = req_r;
  assign imem_addr   = pc_r;
  assign if_valid    = valid_r;
  assign if_instr    = e0_instr_r;
  assign if_opcode   = e0_instr_r[6:0];
  assign if_pc       = e0_pc_r;
  assign fetch_fault = fault_r;

  // next buffer contents: entry 0 is always the head, entry 1 the tail
  always_comb begin
    cnt_nxt_s      = cnt_r;
    e0_instr_nxt_s = e0_instr_r;
    e0_pc_nxt_s    = e0_pc_r;
    e1_instr_nxt_s = e1_instr_r;
    e1_pc_nxt_s    = e1_pc_r;
    if (flush_s) begin
      cnt_nxt_s = 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b11: begin
          if (cnt_r == 2'd1) begin
            e0_instr_nxt_s = imem_rdata;
            e0_pc_nxt_s    = req_pc_r;
          end else begin
            e0_instr_nxt_s = e1_instr_r;
            e0_pc_nxt_s    = e1_pc_r;
            e1_instr_nxt_s = imem_rdata;
            e1_pc_nxt_s    = req_pc_r;
          end
        end
        2'b10: begin
          cnt_nxt_s = cnt_r + 2'd1;
          if (cnt_r == 2'd0) begin
            e0_instr_nxt_s = imem_rdata;
            e0_pc_nxt_s    = req_pc_r;
          end else begin
            e1_instr_nxt_s = imem_rdata;
            e1_pc_nxt_s    = req_pc_r;
          end
        end
        2'b01: begin
          cnt_nxt_s      = cnt_r - 2'd1;
          e0_instr_nxt_s = e1_instr_r;
          e0_pc_nxt_s    = e1_pc_r;
        end
        default: begin
          cnt_nxt_s = cnt_r;
        end
      endcase
    end
  end

  // fetch sequencing, PC update, kill tracking and redirect/fault handling
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    kill_nxt_s  = kill_r;
    fault_nxt_s = fault_r;
    if (flush_s) begin
      if (misalign_s) begin
        state_nxt_s = S_FAULT;
        fault_nxt_s = 1'b1;
        kill_nxt_s  = 1'b0;
      end else begin
        pc_nxt_s = target_s;
        if (grant_s || ((state_r == S_WAIT) && !imem_rvalid)) begin
          kill_nxt_s  = 1'b1;
          state_nxt_s = S_WAIT;
        end else begin
          kill_nxt_s  = 1'b0;
          state_nxt_s = S_REQ;
        end
      end
    end else begin
      case (state_r)
        S_IDLE: state_nxt_s = S_REQ;
        S_REQ: begin
          if (grant_s) begin
            state_nxt_s = S_WAIT;
            pc_nxt_s    = pc_r + 32'd4;
          end else begin
            state_nxt_s = S_REQ;
          end
        end
        S_WAIT: begin
          if (resp_s) begin
            kill_nxt_s  = 1'b0;
            state_nxt_s = credit_s ? S_REQ : S_FULL;
          end else begin
            state_nxt_s = S_WAIT;
          end
        end
        S_FULL:  state_nxt_s = credit_s ? S_REQ : S_FULL;
        S_FAULT: state_nxt_s = S_FAULT;
        default: state_nxt_s = S_IDLE;
      endcase
    end
  end

  // control state registers
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_r  <= S_IDLE;
      pc_r     <= RESET_PC;
      req_pc_r <= RESET_PC;
      kill_r   <= 1'b0;
      fault_r  <= 1'b0;
      req_r    <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      pc_r     <= pc_nxt_s;
      req_pc_r <= grant_s ? pc_r : req_pc_r;
      kill_r   <= kill_nxt_s;
      fault_r  <= fault_nxt_s;
      req_r    <= (state_nxt_s == S_REQ);
    end
  end

  // instruction buffer registers; head entry drives the decode outputs
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      cnt_r      <= 2'd0;
      valid_r    <= 1'b0;
      e0_instr_r <= 32'd0;
      e0_pc_r    <= 32'd0;
      e1_instr_r <= 32'd0;
      e1_pc_r    <= 32'd0;
    end else begin
      cnt_r      <= cnt_nxt_s;
      valid_r    <= (cnt_nxt_s != 2'd0);
      e0_instr_r <= e0_instr_nxt_s;
      e0_pc_r    <= e0_pc_nxt_s;
      e1_instr_r <= e1_instr_nxt_s;
      e1_pc_r    <= e1_pc_nxt_s;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small instruction-memory responder.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [6:0]  if_opcode;
  logic [31:0] if_pc;
  logic        id_ready = 1'b1;
  logic [1:0]  pc_src = 2'd0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic [31:0] jalr_target = 32'd0;
  logic        fetch_fault;

  int          errs = 0;
  int          checks = 0;
  logic [31:0] glog[$];
  logic        pend = 1'b0;
  logic [31:0] paddr = 32'd0;
  logic        rv_hold = 1'b0;
  int          gsize;

  fetch_unit dut (
    .clk(clk), .n_rst(n_rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_opcode(if_opcode), .if_pc(if_pc),
    .id_ready(id_ready), .pc_src(pc_src), .branch_taken(branch_taken),
    .branch_target(branch_target), .jalr_target(jalr_target),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // memory contents: opcode field carries address bits [8:2]
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[24:0], a[8:2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one clock; also plays the memory: grant seen before the edge, data after
  task automatic tick();
    if (imem_req === 1'b1 && imem_gnt && !n_rst) begin
      pend  = 1'b1;
      paddr = imem_addr;
      glog.push_back(imem_addr);
    end
    @(posedge clk);
    #1;
    if (pend && !rv_hold) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem(paddr);
      pend        = 1'b0;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic reset_dut();
    n_rst = 1'b1;
    pend = 1'b0; rv_hold = 1'b0; imem_rvalid = 1'b0;
    tick(); tick();
    glog.delete();
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (if_valid !== 1'b1 && n < 50) begin tick(); n++; end
    chk(tag, {31'd0, if_valid}, 32'd1);
  endtask

  task automatic wait_req(input string tag, input logic [31:0] a);
    int n = 0;
    while (!(imem_req === 1'b1 && imem_addr === a) && n < 50) begin tick(); n++; end
    chk(tag, imem_addr, a);
  endtask

  // a push into a full buffer must never happen
  always @(negedge clk) begin
    if (!n_rst && dut.push_s) begin
      checks++;
      assert (!(dut.cnt_r == 2'd2 && !dut.pop_s)) else begin
        errs++;
        $error("FAIL push_on_full: observed count %0d expected below 2", dut.cnt_r);
      end
    end
  end

  initial begin
    // reset values and in-order streaming
    #1;
    reset_dut();
    chk("rst_req",   {31'd0, imem_req}, 32'd0);
    chk("rst_addr",  imem_addr, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    n_rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_valid("s1_valid");
      chk("s1_pc",     if_pc, 32'(4 * k));
      chk("s1_instr",  if_instr, mem(32'(4 * k)));
      chk("s1_opcode", {25'd0, if_opcode}, {25'd0, mem(32'(4 * k))[6:0]});
      tick();
    end
    chk("s1_g0", glog[0], 32'h0);
    chk("s1_g1", glog[1], 32'h4);
    chk("s1_g2", glog[2], 32'h8);

    // back-pressure fills the buffer with exactly two entries
    id_ready = 1'b0;
    reset_dut();
    n_rst = 1'b0;
    repeat (12) tick();
    chk("s2_valid", {31'd0, if_valid}, 32'd1);
    chk("s2_pc",    if_pc, 32'h0);
    chk("s2_req",   {31'd0, imem_req}, 32'd0);
    chk("s2_ngnt",  32'(glog.size()), 32'd2);
    id_ready = 1'b1;
    tick();
    chk("s2_req8",  {31'd0, imem_req}, 32'd1);
    chk("s2_addr8", imem_addr, 32'h8);
    chk("s2_pc4",   if_pc, 32'h4);
    tick();
    wait_valid("s2_valid8");
    chk("s2_pc8",   if_pc, 32'h8);
    chk("s2_ngnt3", 32'(glog.size()), 32'd3);

    // taken branch while the 0xC request is outstanding
    reset_dut();
    n_rst = 1'b0;
    wait_req("s3_reqC", 32'hC);
    id_ready = 1'b0;
    rv_hold = 1'b1;
    tick();
    chk("s3_pre_pc", if_pc, 32'h8);
    pc_src = 2'd1; branch_taken = 1'b1; branch_target = 32'h100;
    tick();
    pc_src = 2'd0; branch_taken = 1'b0;
    chk("s3_flush",  {31'd0, if_valid}, 32'd0);
    chk("s3_noreq",  {31'd0, imem_req}, 32'd0);
    rv_hold = 1'b0;
    tick();
    tick();
    chk("s3_drop",   {31'd0, if_valid}, 32'd0);
    chk("s3_req",    {31'd0, imem_req}, 32'd1);
    chk("s3_addr",   imem_addr, 32'h100);
    id_ready = 1'b1;
    wait_valid("s3_valid");
    chk("s3_pc",     if_pc, 32'h100);
    chk("s3_instr",  if_instr, mem(32'h100));

    // not-taken branch leaves sequential fetch alone
    pc_src = 2'd1; branch_taken = 1'b0; branch_target = 32'h300;
    tick();
    wait_valid("s4_valid");
    chk("s4_pc104", if_pc, 32'h104);
    tick();
    wait_valid("s4_valid2");
    chk("s4_pc108", if_pc, 32'h108);
    pc_src = 2'd0;

    // redirect to the top of the address space, PC wraps to zero
    pc_src = 2'd1; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    pc_src = 2'd0; branch_taken = 1'b0;
    wait_valid("s5_valid");
    chk("s5_pctop", if_pc, 32'hFFFF_FFFC);
    tick();
    wait_valid("s5_valid2");
    chk("s5_pcwrap", if_pc, 32'h0);

    // jalr clears bit0 of an otherwise aligned target
    pc_src = 2'd2; jalr_target = 32'h401;
    tick();
    pc_src = 2'd0;
    wait_valid("s6_valid");
    chk("s6_pc",    if_pc, 32'h400);
    chk("s6_fault", {31'd0, fetch_fault}, 32'd0);

    // misaligned jalr target is a sticky fault
    pc_src = 2'd2; jalr_target = 32'h203;
    tick();
    pc_src = 2'd0;
    chk("s7_fault", {31'd0, fetch_fault}, 32'd1);
    chk("s7_req",   {31'd0, imem_req}, 32'd0);
    chk("s7_valid", {31'd0, if_valid}, 32'd0);
    gsize = glog.size();
    repeat (5) tick();
    chk("s7_hold",  {31'd0, fetch_fault}, 32'd1);
    chk("s7_req2",  {31'd0, imem_req}, 32'd0);
    chk("s7_ngnt",  32'(glog.size()), 32'(gsize));
    #2 n_rst = 1'b1;
    #1;
    chk("s7_rst_fault", {31'd0, fetch_fault}, 32'd0);

    // asynchronous reset in the middle of a wait with data buffered
    id_ready = 1'b0;
    reset_dut();
    n_rst = 1'b0;
    wait_req("s8_req4", 32'h4);
    rv_hold = 1'b1;
    tick();
    chk("s8_valid", {31'd0, if_valid}, 32'd1);
    #2 n_rst = 1'b1;
    #1;
    chk("s8_req",   {31'd0, imem_req}, 32'd0);
    chk("s8_addr",  imem_addr, 32'h0);
    chk("s8_vld0",  {31'd0, if_valid}, 32'd0);
    chk("s8_fault", {31'd0, fetch_fault}, 32'd0);
    @(posedge clk);
    #1;
    pend = 1'b0; rv_hold = 1'b0; imem_rvalid = 1'b0;
    glog.delete();
    n_rst = 1'b0;
    tick();
    chk("s8_restart_req",  {31'd0, imem_req}, 32'd1);
    chk("s8_restart_addr", imem_addr, 32'h0);
    id_ready = 1'b1;
    wait_valid("s8_valid2");
    chk("s8_pc0", if_pc, 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
